// File: rtl/scfifo_pkg.sv
// Shared constants and width helper for the stream FIFO with registered-read RAM.
package scfifo_pkg;

    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_DEPTH      = 12;

    // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit signal.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/scfifo_stream_rd_out_skid.sv
// Two-entry output buffer that absorbs the RAM read latency; head word drives m_data.
module fifo_out_skid
    import scfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem0_q, mem0_d;
    logic [DATA_WIDTH-1:0] mem1_q, mem1_d;
    logic [1:0]            cnt_q, cnt_d;

    always_comb begin
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        cnt_d  = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    mem0_d = push_data;
                    cnt_d  = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    mem1_d = push_data;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                if (cnt_q != 2'd0) begin
                    mem0_d = mem1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
            end
            2'b11: begin
                // Count is unchanged; only the slot receiving the new word depends on occupancy.
                if (cnt_q == 2'd2) begin
                    mem0_d = mem1_q;
                    mem1_d = push_data;
                end else begin
                    mem0_d = push_data;
                    cnt_d  = 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem0_q <= '0;
            mem1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = mem0_q;
    assign count   = cnt_q;

endmodule

// File: rtl/scfifo_stream_rd.sv
// Single-clock valid/ready FIFO: circular RAM with registered read, read-ahead issue
// logic and a 2-entry output buffer giving first-word-fall-through at full rate.
module scfifo_stream_rd
    import scfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = clog2_min1(DEPTH),
    parameter int LVL_WIDTH  = clog2_min1(DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LVL_WIDTH-1:0]  level,
    output logic                  full,
    output logic                  empty
);

    localparam int CNT_W = clog2_min1(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      RAM_FULL  = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] ram_rd_data;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
    logic                  inflight_q, inflight_d;

    logic       wr_en;
    logic       pop;
    logic       issue;
    logic [1:0] buf_cnt;
    logic [2:0] occ;

    assign s_ready = (ram_cnt_q != RAM_FULL);
    assign wr_en   = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    // Read ahead only while the buffer plus the in-flight word leaves room after this cycle's pop.
    assign occ   = {1'b0, buf_cnt} + {2'b00, inflight_q};
    assign issue = (ram_cnt_q != '0) && (occ < (pop ? 3'd3 : 3'd2));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = issue;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (issue) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        end
        ram_cnt_d = ram_cnt_q + CNT_W'(wr_en) - CNT_W'(issue);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    // Plain memory block, deliberately without reset so it maps onto RAM with an output register.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_ptr_q] <= s_data;
        end
        if (issue) begin
            ram_rd_data <= ram[rd_ptr_q];
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (inflight_q),
        .push_data(ram_rd_data),
        .pop      (pop),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .count    (buf_cnt)
    );

    assign level = LVL_WIDTH'(ram_cnt_q) + LVL_WIDTH'(inflight_q) + LVL_WIDTH'(buf_cnt);
    assign full  = !s_ready;
    assign empty = (level == '0);

endmodule

// File: tb/tb_scfifo_stream_rd.sv
// Scoreboard bench for scfifo_stream_rd: accepted words go into exp_q, a negedge monitor
// checks every pop, level against an accepted-minus-popped count, and stall stability.
module tb_scfifo_stream_rd;

    localparam int DW    = 10;
    localparam int DEPTH = 12;
    localparam int AW    = 4;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    int model_lvl = 0;
    int pop_cnt = 0;
    bit chk_en = 1'b0;
    bit stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    scfifo_stream_rd #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .LVL_WIDTH (LW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_empty"}, empty, 1);
    endtask

    // Monitor / scoreboard: samples mid-cycle, handshakes complete at the following edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("level_model", level, model_lvl);
            chk("empty_model", empty, (model_lvl == 0) ? 1 : 0);
            chk("full_vs_ready", full, s_ready ? 0 : 1);
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, stall_data);
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                model_lvl++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_empty actual=%0d expected=no_word", m_data);
                end else begin
                    chk("m_data", m_data, exp_q.pop_front());
                end
                model_lvl--;
                pop_cnt++;
            end
        end
    end

    initial begin
        int acc;
        int cyc;
        int pc0;
        bit seen;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        chk_reset_values("rst");
        step();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        step();

        // Single word fall-through latency
        s_valid = 1'b1;
        s_data  = 10'h155;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk("t1_level_n", level, 1);
        chk("t1_valid_n", m_valid, 0);
        step();
        chk("t1_valid_n1", m_valid, 0);
        step();
        chk("t1_valid_n2", m_valid, 1);
        chk("t1_data_n2", m_data, 10'h155);
        chk("t1_level_n2", level, 1);
        step();
        chk("t1_level_end", level, 0);
        chk("t1_empty_end", empty, 1);

        // Fill with stalled consumer: DEPTH in RAM plus 2 buffered
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            chk("t2_s_ready_fill", s_ready, 1);
            step();
        end
        chk("t2_full", full, 1);
        chk("t2_s_ready", s_ready, 0);
        chk("t2_level", level, DEPTH + 2);
        s_data = 10'd99;
        step();
        step();
        s_valid = 1'b0;
        chk("t2_level_ignored", level, DEPTH + 2);

        // Drain back-to-back
        chk("t3_full_before", full, 1);
        m_ready = 1'b1;
        step();
        chk("t3_full_drop", full, 0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            chk("t3_no_bubble", m_valid, 1);
            step();
        end
        chk("t3_level_end", level, 0);
        chk("t3_queue_end", exp_q.size(), 0);

        // Streaming with pointer wrap
        pc0 = pop_cnt;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1;
            s_data  = DW'($urandom_range(0, 1023));
            step();
            chk("t4_s_ready", s_ready, 1);
            if (i >= 2) chk("t4_stream_valid", m_valid, 1);
        end
        s_valid = 1'b0;
        repeat (4) step();
        chk("t4_pop_count", pop_cnt - pc0, 40);
        chk("t4_level_end", level, 0);

        // Random traffic
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom_range(0, 1023));
            m_ready = 1'($urandom_range(0, 1));
            #0;
            if (s_valid && s_ready) acc++;
            step();
            cyc++;
        end
        chk("t5_accepted", acc, 1000);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 100 && level != 0; i++) step();
        chk("t5_drain_level", level, 0);
        chk("t5_drain_queue", exp_q.size(), 0);

        // Asynchronous reset mid-stream at level 7
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(100 + i);
            step();
        end
        s_valid = 1'b0;
        step();
        step();
        chk("t6_level_pre", level, 7);
        #2;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_reset_values("t6_async");
        exp_q.delete();
        model_lvl  = 0;
        stall_prev = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk_reset_values("t6_post");
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 10'h2A0;
        step();
        s_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (m_valid) seen = 1'b1;
            else step();
        end
        chk("t6_first_valid", seen, 1);
        chk("t6_first_data", m_data, 10'h2A0);
        repeat (3) step();
        chk("t6_level_end", level, 0);
        chk("t6_queue_end", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scfifo_stream_rd.md
# scfifo_stream_rd

Single-clock FIFO with valid/ready handshakes on both sides, built around an internal circular RAM with a 1-cycle registered read. The read-side controller tracks occupancy, issues RAM reads ahead of demand, and absorbs the read latency in a 2-entry output buffer so the consumer sees first-word-fall-through data at full throughput. It sits between a producer stream and any downstream stream consumer in the datapath.

## Interface
- DATA_WIDTH, 10, data bits per word
- DEPTH, 12, RAM words; any value ≥ 2, not required to be a power of two
- ADDR_WIDTH, $clog2(DEPTH), RAM pointer width
- LVL_WIDTH, $clog2(DEPTH+3), width of level
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  producer word valid
- s_ready  out  1  FIFO accepts word; write occurs on s_valid && s_ready
- s_data  in  DATA_WIDTH  producer word
- m_valid  out  1  m_data holds a valid word
- m_ready  in  1  consumer accepts; pop occurs on m_valid && m_ready
- m_data  out  DATA_WIDTH  head word
- level  out  LVL_WIDTH  words held (RAM + in-flight read + output buffer)
- full  out  1  RAM holds DEPTH words (== !s_ready)
- empty  out  1  level == 0

## Operation
- State: wr_ptr, rd_ptr (ADDR_WIDTH), ram_cnt (0..DEPTH), inflight (0/1), buf_cnt (0..2).
- Write: on s_valid && s_ready, ram[wr_ptr] <= s_data; wr_ptr wraps DEPTH-1 -> 0. s_valid without s_ready: no effect.
- s_ready = (ram_cnt != DEPTH), decoded from registers only; no combinational path from m_ready or s_valid.
- Read issue: issue = (ram_cnt != 0) && (buf_cnt + inflight - pop < 2). On issue, rd_ptr advances (wrap DEPTH-1 -> 0), inflight <= 1, else inflight <= 0.
- RAM read data registered; when inflight is 1 the word enters the output buffer at the next edge.
- ram_cnt next = ram_cnt + write - issue; simultaneous write and issue leaves it unchanged.
- Output buffer (fifo_out_skid): 2-entry FIFO; m_valid = buf_cnt != 0; m_data = oldest entry; simultaneous push/pop at buf_cnt 1 or 2 keeps order.
- Read of an address never coincides with its write: issue uses registered ram_cnt, so written data is already stored.
- level = ram_cnt + inflight + buf_cnt; max DEPTH + 2.
- Reset (any time): pointers, counts, inflight, buffer cleared; stored words discarded; RAM array not reset.

## Timing
- Reset values: s_ready 1, m_valid 0, m_data 0, level 0, full 0, empty 1.
- Write at edge N into empty FIFO: issue in cycle N+1, m_valid high after edge N+2 (2-cycle fall-through).
- Steady state with s_valid and m_ready held high: one word in and one out per cycle after initial latency.
- m_data stable while m_valid && !m_ready.
- full asserts after the edge writing the DEPTH-th RAM word; deasserts the cycle after the next issue.
- FIFO can hold DEPTH+2 words when consumer stalls (buffer and in-flight slot fill from RAM).

## Structure
- Package scfifo_pkg: width helper function (clog2 with minimum 1), default DATA_WIDTH/DEPTH constants.
- Sub-module fifo_out_skid: 2-entry output buffer with push/pop, m_valid, m_data, count output.
- Top holds RAM array, pointers, ram_cnt, inflight, issue logic.

## Test plan
- Reset then single write 0x155, m_ready 1 -> m_valid rises 2 cycles after write edge, m_data 0x155, level 1->0, empty back to 1.
- m_ready 0, write 14 words 0..13 with DEPTH 12 -> s_ready/full change after word 14 (12 in RAM + 2 buffered), level 14; 15th s_valid ignored.
- Fill as above, then m_ready 1 -> words 0..13 out in order on consecutive cycles, full drops the cycle after first issue.
- s_valid and m_ready held 1 for 40 words, DEPTH 12 -> pointers wrap 11->0 three times, output matches input order, one word per cycle, no bubbles after latency.
- Random s_valid/m_ready (50%) 1000 words -> scoreboard match, level equals model at every cycle, m_data stable during stall.
- Assert reset_n low mid-stream with level 7 -> all outputs at reset values immediately; next write 0x2A0 emerges as first word.
